// File: rtl/arith_pkg.sv
// arith_pkg: shared types and width helpers for the arithmetic datapath blocks.
//   state_t : divider control states (IDLE / RUN / DONE)
//   qw(n)   : quotient / remainder / divisor width for operand width n
//   dw(n)   : dividend (product word) width for operand width n
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned qw(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned dw(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step.
// Ports:
//   i_r : partial remainder (always < divisor, so N bits suffice)
//   i_q : dividend low bits / quotient shift register
//   i_d : divisor
//   o_r : next partial remainder
//   o_q : next quotient shift register (new quotient bit in LSB)
module seq_div_step #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_r,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_r,
  output logic [N-1:0] o_q
);

  logic [N:0] w_t;

  // Shift the next dividend bit into the partial remainder.
  assign w_t = {i_r, i_q[N-1]};

  // When the trial subtract succeeds the true difference is below the
  // divisor, so the low N bits of the modular subtract are exact.
  always_comb begin
    if (w_t >= {1'b0, i_d}) begin
      o_r = w_t[N-1:0] - i_d;
      o_q = {i_q[N-2:0], 1'b1};
    end else begin
      o_r = w_t[N-1:0];
      o_q = {i_q[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div_2nbyn.sv
// seq_div_2nbyn: iterative restoring divider, 2N-bit dividend by N-bit
// divisor, one quotient bit per clock, valid/ready on both sides.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : operand handshake (dividend[2N], divisor[N])
//   out_valid/out_ready : result handshake (quotient[N], remainder[N])
//   div_zero            : divisor was zero (quotient all ones, remainder = dividend low half)
//   ovf                 : quotient would not fit in N bits (quotient all ones, remainder 0)
// Build option: define SEQDIV_BACK2BACK_EN to accept new operands in DONE
// in the same edge the current result is taken.
module seq_div_2nbyn
  import arith_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           ovf
);

  localparam int unsigned QW = qw(N);
  localparam int unsigned DW = dw(N);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("seq_div_2nbyn: N must be >= 2");
  end

  state_t          r_state, w_state_nxt;
  logic [QW-1:0]   r_rem,   w_rem_nxt;
  logic [QW-1:0]   r_quo,   w_quo_nxt;
  logic [QW-1:0]   r_dvs,   w_dvs_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic            r_dz,    w_dz_nxt;
  logic            r_ovf,   w_ovf_nxt;

  logic [QW-1:0]   w_hi;
  logic [QW-1:0]   w_lo;
  logic [QW-1:0]   w_step_r;
  logic [QW-1:0]   w_step_q;
  logic            w_accept;

  assign w_hi = dividend[DW-1:QW];
  assign w_lo = dividend[QW-1:0];

  // Handshake decode.
`ifdef SEQDIV_BACK2BACK_EN
  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
`else
  assign in_ready = (r_state == IDLE);
`endif
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign div_zero  = r_dz;
  assign ovf       = r_ovf;

  seq_div_step #(.N(QW)) u_step (
    .i_r (r_rem),
    .i_q (r_quo),
    .i_d (r_dvs),
    .o_r (w_step_r),
    .o_q (w_step_q)
  );

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_dvs_nxt   = r_dvs;
    w_cnt_nxt   = r_cnt;
    w_dz_nxt    = r_dz;
    w_ovf_nxt   = r_ovf;

    case (r_state)
      RUN: begin
        w_rem_nxt = w_step_r;
        w_quo_nxt = w_step_q;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: ;
    endcase

    // Accept overrides: only reachable in IDLE, or in DONE when back-to-back is built in.
    if (w_accept) begin
      w_dvs_nxt = divisor;
      w_cnt_nxt = '0;
      if (divisor == '0) begin
        w_state_nxt = DONE;
        w_dz_nxt    = 1'b1;
        w_ovf_nxt   = 1'b0;
        w_quo_nxt   = '1;
        w_rem_nxt   = w_lo;
      end else if (w_hi >= divisor) begin
        // Upper half not below divisor means the quotient needs more than N bits.
        w_state_nxt = DONE;
        w_dz_nxt    = 1'b0;
        w_ovf_nxt   = 1'b1;
        w_quo_nxt   = '1;
        w_rem_nxt   = '0;
      end else begin
        w_state_nxt = RUN;
        w_dz_nxt    = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_quo_nxt   = w_lo;
        w_rem_nxt   = w_hi;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_dvs   <= w_dvs_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dz    <= w_dz_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_seq_div_2nbyn.sv
// tb_seq_div_2nbyn: scoreboard bench for seq_div_2nbyn (N=4).
// Honours SEQDIV_BACK2BACK_EN for the expected accept spacing.
module tb_seq_div_2nbyn;

  localparam int N = 4;
`ifdef SEQDIV_BACK2BACK_EN
  localparam int SPACING = N + 1;
`else
  localparam int SPACING = N + 2;
`endif

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
    int           acc;
    int           off;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;
  logic           ovf;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   or_mode  = 2;
  exp_t sb[$];

  seq_div_2nbyn #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer division plus the exception rules.
  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t        e;
    int unsigned ua, ub, uq;
    ua    = a;
    ub    = b;
    e.acc = 0;
    if (ub == 0) begin
      e.q = '1; e.r = a[N-1:0]; e.dz = 1'b1; e.ovf = 1'b0; e.off = 0;
    end else begin
      uq = ua / ub;
      if (uq >= (1 << N)) begin
        e.q = '1; e.r = '0; e.dz = 1'b0; e.ovf = 1'b1; e.off = 0;
      end else begin
        e.q = N'(uq); e.r = N'(ua % ub); e.dz = 1'b0; e.ovf = 1'b0; e.off = N;
      end
    end
    return e;
  endfunction

  // Consumer side: random, always or never ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks each result on first appearance, then stability while held.
  exp_t         mon_e;
  bit           fresh = 1'b1;
  bit           held  = 1'b0;
  logic [N-1:0] hq, hr;
  logic         hdz, hovf;

  always @(negedge clk) begin
    if (rst) begin
      fresh = 1'b1;
      held  = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got q=%0d r=%0d, required no output", quotient, remainder);
      end else begin
        mon_e = sb[0];
        if (fresh) begin
          chk("latency",   cyc - mon_e.acc, mon_e.off);
          chk("quotient",  int'(quotient),  int'(mon_e.q));
          chk("remainder", int'(remainder), int'(mon_e.r));
          chk("div_zero",  int'(div_zero),  int'(mon_e.dz));
          chk("ovf",       int'(ovf),       int'(mon_e.ovf));
          fresh = 1'b0;
        end else if (held) begin
          chk("hold_quotient",  int'(quotient),  int'(hq));
          chk("hold_remainder", int'(remainder), int'(hr));
          chk("hold_flags",     int'({div_zero, ovf}), int'({hdz, hovf}));
        end
        if (out_ready) begin
          void'(sb.pop_front());
          fresh = 1'b1;
          held  = 1'b0;
        end else begin
          held = 1'b1;
          hq = quotient; hr = remainder; hdz = div_zero; hovf = ovf;
        end
      end
    end
  end

  // Present one operand pair; entered just after a rising edge.
  task automatic send(input logic [2*N-1:0] a, input logic [N-1:0] b, output int acc);
    int   n;
    exp_t e;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, required 1", n);
      acc = -1;
    end else begin
      e     = model(a, b);
      e.acc = cyc + 1;
      acc   = e.acc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = (2*N)'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_quotient"},  int'(quotient),  0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_flags"},     int'({div_zero, ovf}), 0);
  endtask

  initial begin
    int acc, prev, n;
    logic [N-1:0]   b;
    logic [2*N-1:0] a;

    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases with random backpressure.
    or_mode = 0;
    send(8'h8F, 4'd13, acc);
    send(8'd100, 4'd7, acc);
    send(8'h55, 4'd0, acc);
    send(8'hF0, 4'd3, acc);
    drain();

    // Held result under backpressure.
    or_mode = 2;
    @(posedge clk); #2;
    send(8'd225, 4'd15, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("hold_out_valid_seen", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready",  int'(in_ready),  0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    or_mode = 1;
    drain();
    @(negedge clk);
    chk("idle_in_ready",  int'(in_ready),  1);
    chk("idle_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Abort by reset at step count 2, then a clean operation.
    send(8'd200, 4'd13, acc);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'd6, 4'd3, acc);
    drain();

    // Accept spacing with continuous traffic and an always-ready consumer.
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      b = N'($urandom_range(1, (1 << N) - 1));
      a = {N'($urandom_range(0, int'(b) - 1)), N'($urandom)};
      send(a, b, acc);
      if (prev >= 0) chk("accept_spacing", acc - prev, SPACING);
      prev = acc;
    end
    drain();

    // Exhaustive operand sweep with random gaps and backpressure.
    or_mode = 0;
    for (int x = 0; x < (1 << (2*N)); x++) begin
      for (int y = 0; y < (1 << N); y++) begin
        send((2*N)'(x), N'(y), acc);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    or_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
